// File: rtl/frame_scheduler_pkg.sv
// Shared scene/state types for the display scene controller and its pixel path.
package frame_scheduler_pkg;

  localparam int RGB_W = 24;

  typedef enum logic [1:0] {
    SCN_START = 2'd0,
    SCN_GAME  = 2'd1,
    SCN_OVER  = 2'd2
  } scene_e;

  typedef enum logic [2:0] {
    S_START,
    S_GAME,
    S_OVER,
    S_FADE_OUT,
    S_FADE_IN
  } state_e;

  function automatic state_e steady_state(input scene_e sc);
    case (sc)
      SCN_GAME: return S_GAME;
      SCN_OVER: return S_OVER;
      default:  return S_START;
    endcase
  endfunction

endpackage

// File: rtl/frame_scheduler_rgb_scaler.sv
// Combinational per-pixel brightness scaler: each 8-bit channel becomes (c * level) >> FADE_SHIFT.
module rgb_scaler
  import frame_scheduler_pkg::*;
#(
  parameter int FADE_SHIFT = 3
) (
  input  logic [RGB_W-1:0]    rgb_i,
  input  logic [FADE_SHIFT:0] level_i,
  output logic [RGB_W-1:0]    rgb_o
);

  localparam int PROD_W = 8 + FADE_SHIFT + 1;

  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [FADE_SHIFT:0] lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'(lvl);
    return prod[FADE_SHIFT +: 8];
  endfunction

  assign rgb_o = {scale_chan(rgb_i[23:16], level_i),
                  scale_chan(rgb_i[15:8],  level_i),
                  scale_chan(rgb_i[7:0],   level_i)};

endmodule

// File: rtl/frame_scheduler.sv
// Scene controller: picks the active full-screen source and sequences vsync-aligned fade transitions.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int FADE_SHIFT  = 3,
  parameter int HOLD_FRAMES = 60
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vsync,
  input  logic             i_btn,
  input  logic             i_game_over,
  input  logic [RGB_W-1:0] i_rgb_start,
  input  logic [RGB_W-1:0] i_rgb_game,
  input  logic [RGB_W-1:0] i_rgb_over,
  output logic [RGB_W-1:0] o_rgb,
  output logic [1:0]       o_scene,
  output logic             o_game_en,
  output logic             o_busy
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(HOLD_FRAMES);
  localparam logic [FADE_SHIFT:0] LVL_FULL = {1'b1, {FADE_SHIFT{1'b0}}};

  state_e              state_q, state_d;
  scene_e              scene_q, scene_d;
  scene_e              target_q, target_d;
  logic [FADE_SHIFT:0] level_q, level_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [RGB_W-1:0]    rgb_q, rgb_sel, rgb_scaled;
  logic                game_en_q, busy_q;

  always_comb begin
    state_d  = state_q;
    scene_d  = scene_q;
    target_d = target_q;
    level_d  = level_q;
    hold_d   = hold_q;
    case (state_q)
      S_START: if (i_btn) begin
        state_d  = S_FADE_OUT;
        target_d = SCN_GAME;
      end
      S_GAME: if (i_game_over) begin
        state_d  = S_FADE_OUT;
        target_d = SCN_OVER;
      end
      S_OVER: begin
        if (i_btn && (hold_q >= HOLD_MAX)) begin
          state_d  = S_FADE_OUT;
          target_d = SCN_START;
        end else if (i_vsync && (hold_q < HOLD_MAX)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      // The scene swaps only once the screen is fully black.
      S_FADE_OUT: if (i_vsync) begin
        if (level_q == '0) begin
          scene_d = target_q;
          state_d = S_FADE_IN;
        end else begin
          level_d = level_q - 1'b1;
        end
      end
      S_FADE_IN: if (i_vsync) begin
        if (level_q == LVL_FULL) begin
          state_d = steady_state(scene_q);
          hold_d  = '0;
        end else begin
          level_d = level_q + 1'b1;
        end
      end
      default: state_d = S_START;
    endcase
  end

  always_comb begin
    case (scene_q)
      SCN_GAME: rgb_sel = i_rgb_game;
      SCN_OVER: rgb_sel = i_rgb_over;
      default:  rgb_sel = i_rgb_start;
    endcase
  end

  rgb_scaler #(.FADE_SHIFT(FADE_SHIFT)) u_scaler (
    .rgb_i   (rgb_sel),
    .level_i (level_q),
    .rgb_o   (rgb_scaled)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_START;
      scene_q   <= SCN_START;
      target_q  <= SCN_START;
      level_q   <= LVL_FULL;
      hold_q    <= '0;
      rgb_q     <= '0;
      game_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scene_q   <= scene_d;
      target_q  <= target_d;
      level_q   <= level_d;
      hold_q    <= hold_d;
      rgb_q     <= rgb_scaled;
      game_en_q <= (state_d == S_GAME);
      busy_q    <= (state_d == S_FADE_OUT) || (state_d == S_FADE_IN);
    end
  end

  assign o_rgb     = rgb_q;
  assign o_scene   = scene_q;
  assign o_game_en = game_en_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with FADE_SHIFT=2, HOLD_FRAMES=5 and a queued expectation scoreboard.
module tb_frame_scheduler;

  localparam logic [23:0] SRC_START = 24'hFF8040;
  localparam logic [23:0] SRC_GAME  = 24'h12C4FE;
  localparam logic [23:0] SRC_OVER  = 24'h5A9C21;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync, btn, gover;
  logic [23:0] rgb_start, rgb_game, rgb_over;
  logic [23:0] o_rgb;
  logic [1:0]  o_scene;
  logic        o_game_en, o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [23:0] rgb;
    logic [1:0]  scene;
    logic        busy;
    logic        en;
  } exp_t;
  exp_t sb[$];

  frame_scheduler #(.FADE_SHIFT(2), .HOLD_FRAMES(5)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_vsync     (vsync),
    .i_btn       (btn),
    .i_game_over (gover),
    .i_rgb_start (rgb_start),
    .i_rgb_game  (rgb_game),
    .i_rgb_over  (rgb_over),
    .o_rgb       (o_rgb),
    .o_scene     (o_scene),
    .o_game_en   (o_game_en),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] scale(input logic [23:0] px, input int lvl);
    int r, g, b;
    r = (int'(px[23:16]) * lvl) / 4;
    g = (int'(px[15:8])  * lvl) / 4;
    b = (int'(px[7:0])   * lvl) / 4;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v, input logic b, input logic g);
    vsync = v; btn = b; gover = g;
    @(posedge clk); #1;
    vsync = 1'b0; btn = 1'b0; gover = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [23:0] rgb, input logic [1:0] sc,
                            input logic bsy, input logic en);
    exp_t x;
    x.tag = tag; x.rgb = rgb; x.scene = sc; x.busy = bsy; x.en = en;
    sb.push_back(x);
    @(posedge clk); #1;
    x = sb.pop_front();
    chk({x.tag, "_rgb"},   32'(o_rgb),     32'(x.rgb));
    chk({x.tag, "_scene"}, 32'(o_scene),   32'(x.scene));
    chk({x.tag, "_busy"},  32'(o_busy),    32'(x.busy));
    chk({x.tag, "_gen"},   32'(o_game_en), 32'(x.en));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; vsync = 1'b0; btn = 1'b0; gover = 1'b0;
    rgb_start = SRC_START; rgb_game = SRC_GAME; rgb_over = SRC_OVER;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rgb",   32'(o_rgb),     32'h0);
    chk("rst_scene", 32'(o_scene),   32'h0);
    chk("rst_busy",  32'(o_busy),    32'h0);
    chk("rst_gen",   32'(o_game_en), 32'h0);
    expect_out("idle_pass", 24'hFF8040, 2'd0, 1'b0, 1'b0);

    // START -> GAME
    tick(1'b0, 1'b1, 1'b0);
    expect_out("fo1_start", SRC_START, 2'd0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0); expect_out("fo1_l3", 24'hBF6030, 2'd0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0); expect_out("fo1_l2", 24'h7F4020, 2'd0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0); expect_out("fo1_l1_btn", 24'h3F2010, 2'd0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0); expect_out("fo1_l0", 24'h000000, 2'd0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0); expect_out("fi1_swap", 24'h000000, 2'd1, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      expect_out($sformatf("fi1_l%0d", i), scale(SRC_GAME, i), 2'd1, 1'b1, 1'b0);
    end
    tick(1'b1, 1'b0, 1'b0);
    expect_out("game_steady", SRC_GAME, 2'd1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    expect_out("game_btn_ign", SRC_GAME, 2'd1, 1'b0, 1'b1);

    // GAME -> OVER, event coinciding with vsync
    tick(1'b1, 1'b0, 1'b1);
    chk("go_gen_drop", 32'(o_game_en), 32'h0);
    expect_out("go_same_vs", SRC_GAME, 2'd1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      tick(1'b1, 1'b0, 1'b0);
      expect_out($sformatf("fo2_l%0d", i), scale(SRC_GAME, i), 2'd1, 1'b1, 1'b0);
    end
    tick(1'b1, 1'b0, 1'b0);
    expect_out("fi2_swap", 24'h000000, 2'd2, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      expect_out($sformatf("fi2_l%0d", i), scale(SRC_OVER, i), 2'd2, 1'b1, 1'b0);
    end
    tick(1'b1, 1'b0, 1'b0);
    expect_out("over_steady", SRC_OVER, 2'd2, 1'b0, 1'b0);

    // Hold window in OVER
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    expect_out("hold3_ign", SRC_OVER, 2'd2, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    expect_out("hold4_ign", SRC_OVER, 2'd2, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    expect_out("hold5_acc", SRC_OVER, 2'd2, 1'b1, 1'b0);

    // Reset mid-fade at level 1
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    expect_out("fo3_l1", scale(SRC_OVER, 1), 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_rgb",   32'(o_rgb),     32'h0);
    chk("mid_rst_scene", 32'(o_scene),   32'h0);
    chk("mid_rst_busy",  32'(o_busy),    32'h0);
    chk("mid_rst_gen",   32'(o_game_en), 32'h0);
    expect_out("post_rst_pass", SRC_START, 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
